cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 217 +++++++++++++++++++++
 tb/tb_cmd_parser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// ---------------------------------------------------------------------------
// cmd_parser
//
// Byte-stream command parser sitting between a UART and main_memory.
//   write : 'W' (8'h57), addr, data  -> one o_mem_wr pulse, then ACK_BYTE
//   read  : 'R' (8'h52), addr        -> memory read, then the read byte
//   other : any other first byte     -> NAK_BYTE
// The response byte is held on o_tx_data with o_tx_valid high until the
// transmitter accepts it with i_tx_ready.
//
// Ports
//   i_clk       single rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_rx_data   received byte, qualified by i_rx_valid (one-cycle strobe)
//   o_tx_data   response byte, qualified by o_tx_valid
//   i_tx_ready  transmitter accepts the pending byte this cycle
//   o_mem_addr  register address to main_memory (held between commands)
//   o_mem_data  write data to main_memory (held between commands)
//   o_mem_wr    one-cycle write strobe
//   i_mem_data  read data, valid one cycle after o_mem_addr
//   o_busy      high whenever the parser is not idle
//
// Optional feature
//   CMD_TIMEOUT_EN  when defined, an idle gap of TIMEOUT_CYCLES clocks while
//                   waiting for an address or data byte abandons the command
//                   silently. When undefined, those states wait forever.
//
// ADDR_WIDTH / DATA_WIDTH normally come from address_map.vh (both 8); the
// guarded defaults below match that file so this module builds standalone.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module cmd_parser #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [`ADDR_WIDTH-1:0] o_mem_addr,
    output logic [`DATA_WIDTH-1:0] o_mem_data,
    output logic                   o_mem_wr,
    input  logic [`DATA_WIDTH-1:0] i_mem_data,
    output logic                   o_busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        WRITE    = 3'd3,
        RD_WAIT  = 3'd4,
        RD_CAP   = 3'd5,
        TX       = 3'd6
    } state_t;

    state_t                   state_q,    state_d;
    logic                     cmd_wr_q,   cmd_wr_d;   // 1 = write, 0 = read
    logic [`ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [`DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [7:0]               tx_data_q,  tx_data_d;
    logic                     timeout_hit;

    // -----------------------------------------------------------------------
    // Inter-byte timeout
    // -----------------------------------------------------------------------
`ifdef CMD_TIMEOUT_EN
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        waiting_byte;

    assign waiting_byte = (state_q == GET_ADDR) || (state_q == GET_DATA);

    // A byte arriving in the same cycle as the limit wins over the timeout.
    assign timeout_hit = waiting_byte && !i_rx_valid &&
                         (timeout_cnt_q == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        timeout_cnt_d = timeout_cnt_q;
        // Counter is held at zero outside the waiting states, so entry into
        // GET_ADDR always starts from a cleared count.
        if (i_rx_valid || !waiting_byte || timeout_hit) begin
            timeout_cnt_d = 16'd0;
        end else begin
            timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timeout_cnt_q <= 16'd0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; an incomplete assignment here infers a
        // latch.
        state_d    = state_q;
        cmd_wr_d   = cmd_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        tx_data_d  = tx_data_q;

        unique case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
                        cmd_wr_d = (i_rx_data == CMD_WRITE);
                        state_d  = GET_ADDR;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        state_d   = TX;
                    end
                end
            end

            GET_ADDR: begin
                if (i_rx_valid) begin
                    mem_addr_d = i_rx_data[`ADDR_WIDTH-1:0];
                    state_d    = cmd_wr_q ? GET_DATA : RD_WAIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end

            GET_DATA: begin
                if (i_rx_valid) begin
                    mem_data_d = i_rx_data[`DATA_WIDTH-1:0];
                    state_d    = WRITE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                tx_data_d = ACK_BYTE;
                state_d   = TX;
            end

            // Address was registered on entry; memory data appears one cycle
            // later, so this state only spends that cycle.
            RD_WAIT: begin
                state_d = RD_CAP;
            end

            RD_CAP: begin
                tx_data_d = i_mem_data;
                state_d   = TX;
            end

            TX: begin
                if (i_tx_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cmd_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            tx_data_q  <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            cmd_wr_q   <= cmd_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Strobes decode straight from the state register, so o_mem_wr can only
    // ever be high while in WRITE and drops immediately on reset.
    assign o_mem_wr   = (state_q == WRITE);
    assign o_tx_valid = (state_q == TX);
    assign o_busy     = (state_q != IDLE);
    assign o_tx_data  = tx_data_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;

endmodule

// File: tb/tb_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_cmd_parser
//
// Self-checking bench for cmd_parser with a small registered main_memory
// model. A table of complete commands is applied first, followed by
// hand-written sequences for reset mid-command, response back-pressure,
// bytes arriving during TX, and the inter-byte timeout (CMD_TIMEOUT_EN).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cmd_parser;

    localparam logic [15:0] TB_TIMEOUT = 16'd20;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr;
    logic [7:0] mem_rdata;
    logic       busy;

    int errors = 0;
    int checks = 0;

    cmd_parser #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .ACK_BYTE       (8'h4B),
        .NAK_BYTE       (8'h3F)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_wr   (mem_wr),
        .i_mem_data (mem_rdata),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // main_memory model: write on strobe, read data valid one cycle after
    // the address.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_data;
        mem_rdata <= mem[mem_addr];
    end

    // Write-strobe monitor: each high cycle is counted exactly once.
    int         wr_cnt = 0;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    always @(negedge clk) begin
        if (mem_wr) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_addr;
            wr_data = mem_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Returns the number of cycles from the last strobe cycle to the first
    // cycle with o_tx_valid high (1 = the very next cycle).
    task automatic wait_tx(output int lat);
        lat = 1;
        while (!tx_valid && lat < 50) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    task automatic accept_tx();
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp_tx;
        int         exp_lat;
        int         exp_wr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         lat;
        int         wr_before;
        logic       stable;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vecs[0] = '{3, 8'h57, 8'h02, 8'hA5, 8'h4B, 2, 1};
        vecs[1] = '{3, 8'h57, 8'h02, 8'h05, 8'h4B, 2, 1};
        vecs[2] = '{2, 8'h52, 8'h02, 8'h00, 8'h05, 3, 0};
        vecs[3] = '{3, 8'h57, 8'hFF, 8'hC3, 8'h4B, 2, 1};
        vecs[4] = '{2, 8'h52, 8'hFF, 8'h00, 8'hC3, 3, 0};
        vecs[5] = '{1, 8'h13, 8'h00, 8'h00, 8'h3F, 1, 0};
        vecs[6] = '{2, 8'h52, 8'h02, 8'h00, 8'h05, 3, 0};
        vecs[7] = '{2, 8'h52, 8'h40, 8'h00, 8'h00, 3, 0};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_data", {24'd0, mem_data}, 32'd0);
        check("rst_mem_wr",   {31'd0, mem_wr},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of complete commands
        for (int v = 0; v < 8; v++) begin
            wr_before = wr_cnt;
            send_byte(vecs[v].b0);
            if (vecs[v].nbytes > 1) begin
                check($sformatf("v%0d_busy_mid", v), {31'd0, busy}, 32'd1);
                send_byte(vecs[v].b1);
            end
            if (vecs[v].nbytes > 2) send_byte(vecs[v].b2);
            wait_tx(lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_tx_data", v), {24'd0, tx_data},
                  {24'd0, vecs[v].exp_tx});
            check($sformatf("v%0d_wr_pulses", v), wr_cnt - wr_before,
                  vecs[v].exp_wr);
            if (vecs[v].exp_wr == 1) begin
                check($sformatf("v%0d_wr_addr", v), {24'd0, wr_addr},
                      {24'd0, vecs[v].b1});
                check($sformatf("v%0d_wr_data", v), {24'd0, wr_data},
                      {24'd0, vecs[v].b2});
            end
            if (vecs[v].nbytes > 1) begin
                check($sformatf("v%0d_addr_hold", v), {24'd0, mem_addr},
                      {24'd0, vecs[v].b1});
            end
            // One extra cycle without ready: response must stay put.
            @(negedge clk);
            check($sformatf("v%0d_tx_hold", v), {23'd0, tx_valid, tx_data},
                  {23'd0, 1'b1, vecs[v].exp_tx});
            accept_tx();
            check($sformatf("v%0d_tx_drop", v), {30'd0, tx_valid, busy}, 32'd0);
        end

        // Unknown byte with 10 cycles of back-pressure
        wr_before = wr_cnt;
        send_byte(8'h13);
        wait_tx(lat);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h3F)) stable = 1'b0;
        end
        check("nak_stable_10", {31'd0, stable}, 32'd1);
        check("nak_no_write",  wr_cnt - wr_before, 0);
        accept_tx();
        check("nak_released", {31'd0, tx_valid}, 32'd0);

        // Reset in the middle of a write command
        wr_before = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        check("midrst_async", {27'd0, busy, tx_valid, mem_wr, |mem_addr, |mem_data},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        send_byte(8'hA5);
        wait_tx(lat);
        check("midrst_a5_nak", {24'd0, tx_data}, 32'h3F);
        check("midrst_a5_lat", lat, 1);
        check("midrst_no_write", wr_cnt - wr_before, 0);
        accept_tx();

        // Command byte arriving during TX is ignored
        send_byte(8'h13);
        wait_tx(lat);
        send_byte(8'h57);
        check("tx_ignore_rx", {22'd0, busy, tx_valid, tx_data}, {22'd0, 2'b11, 8'h3F});
        accept_tx();
        check("tx_ignore_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h52);
        send_byte(8'h02);
        wait_tx(lat);
        check("tx_ignore_rd_lat",  lat, 3);
        check("tx_ignore_rd_data", {24'd0, tx_data}, 32'h05);
        accept_tx();

        // Inter-byte timeout
        wr_before = wr_cnt;
        send_byte(8'h57);
        repeat (25) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        check("to_back_idle", {31'd0, busy}, 32'd0);
        check("to_no_resp",   {31'd0, tx_valid}, 32'd0);
        send_byte(8'h01);
        wait_tx(lat);
        check("to_01_nak", {24'd0, tx_data}, 32'h3F);
        check("to_no_write", wr_cnt - wr_before, 0);
        accept_tx();
`else
        check("noto_waiting", {31'd0, busy}, 32'd1);
        send_byte(8'h01);
        repeat (5) @(negedge clk);
        check("noto_addr",    {24'd0, mem_addr}, 32'h01);
        check("noto_in_data", {30'd0, busy, tx_valid}, 32'd2);
        check("noto_no_write", wr_cnt - wr_before, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
